// File: rtl/rv_writeback_arbiter.sv
// Writeback arbiter: merges in-order pipeline results and buffered long-unit
// results onto the single register-file write port. It also keeps a
// scoreboard of destination registers that still have long ops in flight.
module rv_writeback_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    // Pipeline writeback
    input  logic        iPipeWrite,
    input  logic [4:0]  iPipeRd,
    input  logic [31:0] iPipeData,
    output logic        oPipeStall,
    // Long-latency unit results
    input  logic        iLongValid,
    input  logic [4:0]  iLongRd,
    input  logic [31:0] iLongData,
    output logic        oLongReady,
    // Issue / decode hazard interface
    input  logic        iIssueValid,
    input  logic [4:0]  iIssueRd,
    input  logic [4:0]  iRs1,
    input  logic [4:0]  iRs2,
    input  logic [4:0]  iRd,
    output logic        oHazard,
    output logic [31:0] oPendingMask,
    // Register file write port
    output logic        oRegWrite,
    output logic [4:0]  oWriteRegister,
    output logic [31:0] oWriteData
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] StarveMax = CW'(STARVE_LIMIT - 1);
    localparam logic [AW:0]   FifoFull  = (AW + 1)'(DEPTH);

    // FIFO storage and state
    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;

    logic [CW-1:0] r_starve_cnt, w_starve_cnt_d;
    logic          r_pipe_stall, w_pipe_stall_d;
    logic [31:0]   r_pending, w_pending_d;

    logic          r_reg_write;
    logic [4:0]    r_write_reg;
    logic [31:0]   r_write_data;

    logic          w_fifo_empty, w_fifo_full;
    logic          w_long_xfer, w_long_live;
    logic          w_sel_stall_pop, w_sel_pipe, w_sel_pop, w_sel_bypass;
    logic          w_pop, w_push;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;
    logic [31:0]   w_set_mask, w_clr_mask;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == FifoFull);
    assign w_head_rd    = r_mem_rd[r_rd_ptr];
    assign w_head_data  = r_mem_data[r_rd_ptr];

    assign oLongReady   = !w_fifo_full;
    assign w_long_xfer  = iLongValid && oLongReady;
    // rd=0 long results are accepted but never buffered or written
    assign w_long_live  = w_long_xfer && (iLongRd != 5'd0);

    // Output source selection in priority order
    always_comb begin
        w_sel_stall_pop = r_pipe_stall && !w_fifo_empty;
        w_sel_pipe      = !w_sel_stall_pop && iPipeWrite && (iPipeRd != 5'd0) && !r_pipe_stall;
        w_sel_pop       = !w_sel_stall_pop && !w_sel_pipe && !w_fifo_empty;
        w_sel_bypass    = !w_sel_stall_pop && !w_sel_pipe && w_fifo_empty && w_long_live;
        w_pop           = w_sel_stall_pop || w_sel_pop;
        w_push          = w_long_live && !w_sel_bypass;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // FIFO storage write; contents are don't-care while empty
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= iLongRd;
            r_mem_data[r_wr_ptr] <= iLongData;
        end
    end

    // Starvation guard: a head that waits STARVE_LIMIT cycles forces a one-cycle stall
    always_comb begin
        w_starve_cnt_d  = r_starve_cnt;
        w_pipe_stall_d  = 1'b0;
        if (w_fifo_empty || w_pop) begin
            w_starve_cnt_d = '0;
        end else if (r_starve_cnt == StarveMax) begin
            w_starve_cnt_d = '0;
            w_pipe_stall_d = 1'b1;
        end else begin
            w_starve_cnt_d = r_starve_cnt + 1'b1;
        end
    end

    // Starve counter and registered stall
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_starve_cnt <= '0;
            r_pipe_stall <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_d;
            r_pipe_stall <= w_pipe_stall_d;
        end
    end

    // Scoreboard next state: long writes clear, issues set, set wins on collision
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (iIssueValid) w_set_mask[iIssueRd] = 1'b1;
        if (w_pop)        w_clr_mask[w_head_rd] = 1'b1;
        if (w_sel_bypass) w_clr_mask[iLongRd]   = 1'b1;
        w_pending_d      = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_d[0]   = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) r_pending <= '0;
        else      r_pending <= w_pending_d;
    end

    // Register-file write port; address and data hold when idle
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_reg_write <= w_sel_pipe || w_pop || w_sel_bypass;
            if (w_sel_pipe) begin
                r_write_reg  <= iPipeRd;
                r_write_data <= iPipeData;
            end else if (w_pop) begin
                r_write_reg  <= w_head_rd;
                r_write_data <= w_head_data;
            end else if (w_sel_bypass) begin
                r_write_reg  <= iLongRd;
                r_write_data <= iLongData;
            end
        end
    end

    assign oPipeStall     = r_pipe_stall;
    assign oPendingMask   = r_pending;
    assign oHazard        = r_pending[iRs1] | r_pending[iRs2] | r_pending[iRd];
    assign oRegWrite      = r_reg_write;
    assign oWriteRegister = r_write_reg;
    assign oWriteData     = r_write_data;

endmodule
